result_collector: RTL and testbench
===================================

# result_collector

Output-side stage directly downstream of the top-level data interface. It takes the 32-bit result bus, the `y_valid` strobe and the `out_count` announcement, and groups results into frames of the announced length. Results are buffered in a first-word-fall-through FIFO and drained to the host over a valid/ready stream with an end-of-frame marker. It also raises a done pulse and sticky error flags, so the host never has to count words itself.

## Interface
Parameters:
- `WIDTH`, 32: result word width.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1: global clock; the only clock.
- `clear`  in  1: global reset, asynchronous, active-low.
- `enable`  in  1: gates the input side only (result capture, frame counters); the drain side runs regardless.
- `data_in`  in  WIDTH: result word (upstream `data_out`).
- `y_valid`  in  1: `data_in` holds a valid result this cycle.
- `out_count`  in  32: number of results in the next frame.
- `out_count_valid`  in  1: one-cycle strobe qualifying `out_count`.
- `m_data`  out  WIDTH: FIFO head word.
- `m_valid`  out  1: `m_data` is valid.
- `m_ready`  in  1: host accepts; transfer when `m_valid && m_ready`.
- `m_last`  out  1: the head word is the final word of its frame.
- `done`  out  1: one-cycle pulse when a frame is complete.
- `busy`  out  1: the FSM is not in IDLE.
- `level`  out  log2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky; a result was dropped because the FIFO was full.
- `stray`  out  1: sticky; a result arrived in IDLE, or a count was lost.

## Operation
- FSM states: IDLE, ACTIVE, FLUSH.
- `remaining` is a 32-bit register. A one-entry pending register holds `pend_count` and `pend_valid`.
- IDLE:
  - `out_count_valid` with `out_count` > 0 loads `remaining` and moves to ACTIVE.
  - `out_count_valid` with `out_count` == 0 pulses `done` next cycle and stays in IDLE.
  - `y_valid` in IDLE drops the word and sets `stray`.
- ACTIVE: each `y_valid` (with `enable`) decrements `remaining`.
  - If not full, the word is pushed with a tag bit = (`remaining` == 1).
  - If full, the word is dropped and `overflow` is set; the decrement still occurs so frame alignment holds.
  - When `remaining` reaches 0, go to FLUSH.
- FLUSH: extra `y_valid` is dropped and sets `stray`. When the FIFO is empty, pulse `done` for one cycle. Then:
  - if `pend_valid`, load `remaining` from `pend_count`, clear `pend_valid`, go to ACTIVE (a pending count of 0 pulses `done` again and goes to IDLE);
  - otherwise go to IDLE.
- `out_count_valid` in ACTIVE or FLUSH fills the pending register. If `pend_valid` is already set, the new count is ignored and `stray` is set.
- `m_last` is the tag bit of the head entry. If a frame's final word was dropped, no `m_last` appears for that frame, but `done` still fires.
- Full test: a push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
- A simultaneous push and pop leaves `level` unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is detected by occupancy == DEPTH.
- `enable` low: `y_valid` and `out_count_valid` are ignored (no flag updates). Pops continue.

## Timing
- Reset (`clear` low, async) sets every output to 0: `m_data`, `m_valid`, `m_last`, `done`, `busy`, `level`, `overflow`, `stray`. It also sets the FSM to IDLE, pointers to 0, `remaining` to 0 and `pend_valid` to 0. Deassertion mid-frame restarts clean; there is no recovery of lost words.
- Word latency: `y_valid` at edge N writes the FIFO. With the FIFO previously empty, `m_valid` and `m_data` are valid after edge N (fall-through, one cycle).
- `m_data`, `m_valid` and `m_last` stay stable while `m_valid && !m_ready`.
- `done` is asserted in the cycle after FLUSH observes the FIFO empty; it is never high for two consecutive cycles unless zero-length frames are back-to-back.
- `busy` rises the cycle after the count is accepted, and falls the cycle `done` is asserted when nothing is pending.
- Sticky flags clear only on reset.

## Test plan
- Count 3, three `y_valid` words A, B, C, `m_ready` high: outputs A, B, C with `m_last` only on C. `done` pulses once, `busy` returns to 0, `level` ends at 0.
- Count 20 with DEPTH 16 and `m_ready` low: 16 words stored, `level`=16, `overflow`=1. After `m_ready` goes high, 16 words drain, with no `m_last`; `done` fires when empty.
- Count 0: `done` pulses one cycle after the strobe, `busy` stays 0, and no `m_valid`.
- Count 2 followed by count 1 while ACTIVE: the second count is held pending. Three words arrive, `m_last` is set on words 2 and 3, and `done` pulses twice.
- FIFO full with simultaneous push and pop: the push is accepted, `level` stays 16, and `overflow` stays 0.
- `y_valid` in IDLE sets `stray`=1 and nothing is stored. Asserting `clear` low mid-frame zeroes all outputs immediately (asynchronously).

Source files
------------

// File: rtl/result_collector.sv
// result_collector: groups upstream results into frames of an announced
// length, buffers them in a fall-through FIFO and drains them to the host
// over a valid/ready stream with an end-of-frame marker.
module result_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             y_valid,
  input  logic [31:0]      out_count,
  input  logic             out_count_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             done,
  output logic             busy,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic             stray
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t          state, state_n;
  logic [31:0]     remaining, remaining_n;
  logic [31:0]     pend_count, pend_count_n;
  logic            pend_valid, pend_valid_n;
  logic            done_n, overflow_n, stray_n;
  logic            push, push_tag, pop, full;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic            mem_last [DEPTH];

  // Head of FIFO falls through; gated so outputs read 0 while empty/after reset.
  assign m_valid = (level != '0);
  assign m_data  = m_valid ? mem_data[rd_ptr] : '0;
  assign m_last  = m_valid ? mem_last[rd_ptr] : 1'b0;
  assign pop     = m_valid && m_ready;
  assign full    = (level == (AW+1)'(DEPTH));
  assign busy    = (state != IDLE);

  // Next-state and datapath control for the frame FSM.
  always_comb begin
    state_n      = state;
    remaining_n  = remaining;
    pend_count_n = pend_count;
    pend_valid_n = pend_valid;
    done_n       = 1'b0;
    overflow_n   = overflow;
    stray_n      = stray;
    push         = 1'b0;
    push_tag     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && y_valid) stray_n = 1'b1;
        if (enable && out_count_valid) begin
          if (out_count != 32'd0) begin
            remaining_n = out_count;
            state_n     = ACTIVE;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (enable && y_valid) begin
          // Decrement even on a drop so the frame boundary stays aligned.
          remaining_n = remaining - 32'd1;
          if (!full || pop) begin
            push     = 1'b1;
            push_tag = (remaining == 32'd1);
          end else begin
            overflow_n = 1'b1;
          end
          if (remaining == 32'd1) state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (enable && y_valid) stray_n = 1'b1;
        if (level == '0) begin
          done_n = 1'b1;
          if (pend_valid) begin
            pend_valid_n = 1'b0;
            // A zero pending count stays in FLUSH one more cycle, which
            // produces its own done pulse and then returns to IDLE.
            if (pend_count != 32'd0) begin
              remaining_n = pend_count;
              state_n     = ACTIVE;
            end
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && enable && out_count_valid) begin
      if (pend_valid) begin
        stray_n = 1'b1;
      end else begin
        pend_valid_n = 1'b1;
        pend_count_n = out_count;
      end
    end
  end

  // Control state, flags and FIFO pointers.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      remaining  <= '0;
      pend_count <= '0;
      pend_valid <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      stray      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      pend_count <= pend_count_n;
      pend_valid <= pend_valid_n;
      done       <= done_n;
      overflow   <= overflow_n;
      stray      <= stray_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (!push && pop) level <= level - (AW+1)'(1);
    end
  end

  // FIFO storage; contents need no reset since reads are gated by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= data_in;
      mem_last[wr_ptr] <= push_tag;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a pop/done monitor.
module tb_result_collector;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             clear, enable, y_valid, out_count_valid, m_ready;
  logic [WIDTH-1:0] data_in;
  logic [31:0]      out_count;
  logic [WIDTH-1:0] m_data;
  logic             m_valid, m_last, done, busy, overflow, stray;
  logic [4:0]       level;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] pop_q[$];
  logic             last_q[$];
  int done_cnt = 0;

  result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .clear(clear), .enable(enable), .data_in(data_in),
    .y_valid(y_valid), .out_count(out_count), .out_count_valid(out_count_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .done(done), .busy(busy), .level(level), .overflow(overflow), .stray(stray)
  );

  always #5 clk = ~clk;

  // Record host transfers and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (clear) begin
      if (m_valid && m_ready) begin
        pop_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_count(input logic [31:0] c);
    out_count = c; out_count_valid = 1'b1;
    tick();
    out_count_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    data_in = w; y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {m_data, m_valid, m_last, done, busy, level, overflow, stray}, '0);
  endtask

  int n0, d0, lasts;

  initial begin
    clear = 1'b0; enable = 1'b1; y_valid = 1'b0; out_count_valid = 1'b0;
    m_ready = 1'b1; data_in = '0; out_count = '0;
    #12;
    chk_all_zero("reset");
    tick();
    clear = 1'b1;
    tick();

    // Frame of 3 with host always ready.
    n0 = pop_q.size(); d0 = done_cnt;
    send_count(32'd3);
    chk("t1_busy", busy, 1);
    send_word(32'hA0A0_0001);
    send_word(32'hB0B0_0002);
    send_word(32'hC0C0_0003);
    tick(8);
    chk("t1_npop", pop_q.size() - n0, 3);
    if (pop_q.size() - n0 == 3) begin
      chk("t1_w0", {pop_q[n0],   last_q[n0]},   {32'hA0A0_0001, 1'b0});
      chk("t1_w1", {pop_q[n0+1], last_q[n0+1]}, {32'hB0B0_0002, 1'b0});
      chk("t1_w2", {pop_q[n0+2], last_q[n0+2]}, {32'hC0C0_0003, 1'b1});
    end
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_end", {busy, level, m_valid}, 0);

    // Zero-length frame.
    n0 = pop_q.size();
    send_count(32'd0);
    chk("t3_done", {done, busy}, 2'b10);
    tick();
    chk("t3_done_off", done, 0);
    tick(2);
    chk("t3_nopop", pop_q.size() - n0, 0);

    // Count 2 then count 1 held pending.
    n0 = pop_q.size(); d0 = done_cnt;
    send_count(32'd2);
    out_count = 32'd1; out_count_valid = 1'b1;
    data_in = 32'h1111_0001; y_valid = 1'b1;
    tick();
    out_count_valid = 1'b0; y_valid = 1'b0;
    send_word(32'h2222_0002);
    tick(5);
    chk("t4_busy_mid", busy, 1);
    send_word(32'h3333_0003);
    tick(6);
    chk("t4_npop", pop_q.size() - n0, 3);
    if (pop_q.size() - n0 == 3) begin
      chk("t4_w0", {pop_q[n0],   last_q[n0]},   {32'h1111_0001, 1'b0});
      chk("t4_w1", {pop_q[n0+1], last_q[n0+1]}, {32'h2222_0002, 1'b1});
      chk("t4_w2", {pop_q[n0+2], last_q[n0+2]}, {32'h3333_0003, 1'b1});
    end
    chk("t4_done", done_cnt - d0, 2);
    chk("t4_flags", {busy, stray, overflow}, 0);

    // Count 20 into a 16-deep FIFO, host stalled.
    m_ready = 1'b0;
    n0 = pop_q.size(); d0 = done_cnt;
    send_count(32'd20);
    for (int i = 1; i <= 16; i++) send_word(32'h5000_0000 + i);
    chk("t5_full", {level, overflow, m_valid}, {5'd16, 1'b0, 1'b1});
    chk("t5_head", m_data, 32'h5000_0001);
    m_ready = 1'b1;
    send_word(32'h5000_0011);
    m_ready = 1'b0;
    chk("t5_pushpop", {level, overflow}, {5'd16, 1'b0});
    chk("t5_head2", m_data, 32'h5000_0002);
    send_word(32'h5000_0012);
    chk("t5_ovf", {level, overflow}, {5'd16, 1'b1});
    send_word(32'h5000_0013);
    send_word(32'h5000_0014);
    chk("t5_flush_busy", {busy, done}, 2'b10);
    m_ready = 1'b1;
    tick(25);
    chk("t5_npop", pop_q.size() - n0, 17);
    if (pop_q.size() - n0 == 17) begin
      chk("t5_first_drain", pop_q[n0+1], 32'h5000_0002);
      chk("t5_last_drain", pop_q[n0+16], 32'h5000_0011);
      lasts = 0;
      for (int i = n0; i < n0 + 17; i++) lasts += int'(last_q[i]);
      chk("t5_no_mlast", lasts, 0);
    end
    chk("t5_done", done_cnt - d0, 1);
    chk("t5_end", {busy, level}, 0);

    // Stray word in IDLE.
    n0 = pop_q.size();
    send_word(32'hDEAD_BEEF);
    tick(2);
    chk("t6_stray", {stray, level, m_valid}, {1'b1, 5'd0, 1'b0});
    chk("t6_nopop", pop_q.size() - n0, 0);

    // Async clear mid-frame.
    m_ready = 1'b0;
    send_count(32'd5);
    send_word(32'h7777_0001);
    send_word(32'h7777_0002);
    chk("t7_pre", {level, busy}, {5'd2, 1'b1});
    #1 clear = 1'b0;
    #1 chk_all_zero("t7_clear");
    tick();
    clear = 1'b1;
    tick(2);
    chk_all_zero("t7_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
